// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR phase-select controller: FSM encoding and
// phase-count constants.
package cdr_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned SEL_W_DEF = 3;
  localparam int unsigned NPH       = 8;

endpackage

// File: rtl/vote_accum.sv
// Signed up/down vote counter with +/-threshold detect; the counter clears on
// a hit, on clr, or on reset, so |acc| < VOTE_TH always holds.
module vote_accum #(
  parameter int unsigned VOTE_TH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic up,
  input  logic dn,
  output logic hit_up,
  output logic hit_dn
);

  localparam int unsigned AW = $clog2(VOTE_TH) + 1;
  localparam logic signed [AW-1:0] ONE    = AW'(1);
  localparam logic signed [AW-1:0] TH_M1  = AW'(VOTE_TH - 1);
  localparam logic signed [AW-1:0] NTH_M1 = -TH_M1;

  logic signed [AW-1:0] acc;

  // A hit is the vote that would land exactly on +/-VOTE_TH.
  assign hit_up = up && (acc == TH_M1);
  assign hit_dn = dn && (acc == NTH_M1);

  always_ff @(posedge clk) begin
    if (rst || clr || hit_up || hit_dn) begin
      acc <= '0;
    end else if (up) begin
      acc <= acc + ONE;
    end else if (dn) begin
      acc <= acc - ONE;
    end
  end

endmodule

// File: rtl/phase_sel_ctrl.sv
// Phase-select controller for the 8:1 CDR sampling mux: integrates
// early/late votes, steps the select with wrap, holds off, and reports lock.
module phase_sel_ctrl
  import cdr_pkg::*;
#(
  parameter int unsigned VOTE_TH  = 4,
  parameter int unsigned HOLD_CYC = 3,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned SEL_W    = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pd_valid,
  input  logic             pd_early,
  input  logic             pd_late,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic [SEL_W-1:0] sel,
  output logic             step_up,
  output logic             step_dn,
  output logic             locked
);

  localparam int unsigned HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int unsigned LW = $clog2(LOCK_CNT + 1);

  state_t           state, state_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [LW-1:0]    lock_cnt, lock_n;
  logic [SEL_W-1:0] sel_n;
  logic             up_n, dn_n, locked_n;
  logic             vote_ok, hit_up, hit_dn;

  assign vote_ok = (state == ACCUM) && pd_valid && (pd_early ^ pd_late) && !force_en;

  vote_accum #(
    .VOTE_TH (VOTE_TH)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (force_en),
    .up     (vote_ok && pd_early),
    .dn     (vote_ok && pd_late),
    .hit_up (hit_up),
    .hit_dn (hit_dn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      hold_cnt <= '0;
      lock_cnt <= '0;
      sel      <= '0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      lock_cnt <= lock_n;
      sel      <= sel_n;
      step_up  <= up_n;
      step_dn  <= dn_n;
      locked   <= locked_n;
    end
  end

  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    lock_n   = lock_cnt;
    sel_n    = sel;
    up_n     = 1'b0;
    dn_n     = 1'b0;
    locked_n = locked;
    if (force_en) begin
      sel_n    = force_sel;
      lock_n   = '0;
      locked_n = 1'b0;
      state_n  = ACCUM;
      hold_n   = '0;
    end else if (state == HOLD) begin
      if (hold_cnt <= HW'(1)) begin
        state_n = ACCUM;
        hold_n  = '0;
      end else begin
        hold_n = hold_cnt - HW'(1);
      end
    end else if (hit_up || hit_dn) begin
      sel_n    = hit_up ? sel + SEL_W'(1) : sel - SEL_W'(1);
      up_n     = hit_up;
      dn_n     = hit_dn;
      lock_n   = '0;
      locked_n = 1'b0;
      if (HOLD_CYC > 0) begin
        state_n = HOLD;
        hold_n  = HW'(HOLD_CYC);
      end
    end else if (vote_ok) begin
      // Saturating count; locked asserts on the edge the count reaches LOCK_CNT.
      if (lock_cnt != LW'(LOCK_CNT)) lock_n = lock_cnt + LW'(1);
      if (lock_n == LW'(LOCK_CNT)) locked_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_sel_ctrl.sv
// Self-checking bench for phase_sel_ctrl: integer-level reference model
// compared every cycle, plus hand-computed checkpoints along directed stimulus.
module tb_phase_sel_ctrl;
  import cdr_pkg::*;

  localparam int VOTE_TH  = 4;
  localparam int HOLD_CYC = 3;
  localparam int LOCK_CNT = 16;
  localparam int SEL_W    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pd_valid = 1'b0;
  logic             pd_early = 1'b0;
  logic             pd_late = 1'b0;
  logic             force_en = 1'b0;
  logic [SEL_W-1:0] force_sel = '0;
  logic [SEL_W-1:0] sel;
  logic             step_up, step_dn, locked;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phase_sel_ctrl #(
    .VOTE_TH  (VOTE_TH),
    .HOLD_CYC (HOLD_CYC),
    .LOCK_CNT (LOCK_CNT),
    .SEL_W    (SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pd_valid  (pd_valid),
    .pd_early  (pd_early),
    .pd_late   (pd_late),
    .force_en  (force_en),
    .force_sel (force_sel),
    .sel       (sel),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .locked    (locked)
  );

  // Reference model: phase index, net vote count, remaining hold cycles,
  // votes since last step, and the expected registered outputs.
  int m_sel = 0, m_acc = 0, m_hold = 0, m_votes = 0;
  bit m_up = 0, m_dn = 0, m_locked = 0, started = 0;

  always @(posedge clk) begin
    started = 1;
    m_up = 0;
    m_dn = 0;
    if (rst) begin
      m_sel = 0; m_acc = 0; m_hold = 0; m_votes = 0; m_locked = 0;
    end else if (force_en) begin
      m_sel = int'(force_sel); m_acc = 0; m_hold = 0; m_votes = 0; m_locked = 0;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end else if (pd_valid && (pd_early != pd_late)) begin
      m_acc = m_acc + (pd_early ? 1 : -1);
      if (m_acc == VOTE_TH || m_acc == -VOTE_TH) begin
        m_up = (m_acc > 0);
        m_dn = (m_acc < 0);
        m_sel = (m_sel + (m_up ? 1 : NPH - 1)) % NPH;
        m_acc = 0; m_votes = 0; m_locked = 0; m_hold = HOLD_CYC;
      end else begin
        if (m_votes < LOCK_CNT) m_votes = m_votes + 1;
        if (m_votes == LOCK_CNT) m_locked = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (sel !== SEL_W'(m_sel) || step_up !== m_up || step_dn !== m_dn || locked !== m_locked) begin
        errors++;
        $display("FAIL cycle_model t=%0t: sel=%0d up=%0b dn=%0b locked=%0b, required sel=%0d up=%0b dn=%0b locked=%0b",
                 $time, sel, step_up, step_dn, locked, m_sel, m_up, m_dn, m_locked);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the sampling edge.
  task automatic cyc(input bit r, input bit v, input bit e, input bit l,
                     input bit f = 0, input int fs = 0);
    rst = r; pd_valid = v; pd_early = e; pd_late = l;
    force_en = f; force_sel = SEL_W'(fs);
    @(posedge clk);
    #1;
  endtask

  task automatic votes(input int n, input bit early);
    for (int i = 0; i < n; i++) cyc(0, 1, early, !early);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    // 1. Reset with votes active
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("reset_sel", int'(sel), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_pulses", int'({step_up, step_dn}), 0);
    votes(1, 1);
    chk("post_reset_single_vote", int'({sel, step_up}), 0);

    // 2. Up step and hold-off
    cyc(1, 0, 0, 0);
    votes(3, 1);
    chk("pre_step_sel", int'(sel), 0);
    votes(1, 1);
    chk("step1_sel", int'(sel), 1);
    chk("step1_pulse", int'(step_up), 1);
    votes(3, 1);
    chk("hold_sel", int'(sel), 1);
    chk("pulse_one_cycle", int'(step_up), 0);
    votes(4, 1);
    chk("step2_sel", int'(sel), 2);

    // 3. Wrap-around both directions
    cyc(0, 0, 0, 0, 1, 7);
    chk("force7", int'(sel), 7);
    votes(4, 1);
    chk("wrap_up_sel", int'(sel), 0);
    chk("wrap_up_pulse", int'(step_up), 1);
    cyc(0, 0, 0, 0, 1, 0);
    votes(4, 0);
    chk("wrap_dn_sel", int'(sel), 7);
    chk("wrap_dn_pulse", int'(step_dn), 1);

    // 4. Lock
    idle(HOLD_CYC);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, (i % 2) == 0, (i % 2) == 1);
      if (i == 14) chk("lock_15th", int'(locked), 0);
      if (i == 15) chk("lock_16th", int'(locked), 1);
    end
    chk("lock_sel", int'(sel), 7);
    votes(4, 1);
    chk("lock_step_sel", int'(sel), 0);
    chk("unlock_on_step", int'({step_up, locked}), 2);

    // 5. Vote filtering
    idle(HOLD_CYC);
    votes(3, 1);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 0);
    chk("filtered_no_step", int'(sel), 0);
    votes(1, 1);
    chk("filter_final_step", int'(sel), 1);

    // 6. Force during HOLD, then reset mid-accumulation
    cyc(0, 1, 1, 0, 1, 5);
    chk("force_in_hold", int'({sel, step_up, step_dn}), 5 << 2);
    votes(4, 1);
    chk("after_force_sel", int'(sel), 6);
    idle(HOLD_CYC);
    votes(3, 1);
    cyc(1, 1, 1, 0);
    votes(1, 1);
    chk("reset_clears_acc", int'({sel, step_up}), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sel_ctrl.md
Name: phase_sel_ctrl

Overview:
Controller for the 8:1 phase-select mux in the multiphase CDR. It integrates early/late votes from the bang-bang phase detector and drives the mux select to step the sampling phase up or down one position, with wrap-around. A hold-off interval after each step lets the new phase settle. A lock indicator reports when no step has occurred for a sustained run of votes. A manual override forces a fixed phase for bring-up and test.

Parameters:
VOTE_TH, 4, net vote count that triggers a phase step (≥1)
HOLD_CYC, 3, cycles after a step during which votes are ignored (0 = no hold-off)
LOCK_CNT, 16, accepted votes without a step required to assert locked
SEL_W, 3, select width; number of phases = 2**SEL_W

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pd_valid  in  1  phase-detector vote strobe
pd_early  in  1  vote: advance phase (sel+1)
pd_late  in  1  vote: retard phase (sel-1)
force_en  in  1  manual override enable
force_sel  in  SEL_W  phase applied while force_en=1
sel  out  SEL_W  registered mux select
step_up  out  1  one-cycle pulse on an up step
step_dn  out  1  one-cycle pulse on a down step
locked  out  1  lock indicator

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: sel=0, step_up=0, step_dn=0, locked=0, acc=0, lock_cnt=0, hold_cnt=0, state=ACCUM. Reset overrides every other input, including a reset asserted mid-hold-off or mid-accumulation.
- Accepted vote: a cycle in ACCUM with pd_valid=1 and exactly one of pd_early or pd_late set.
- Ignored cycles: pd_valid=0, or both pd_early and pd_late set, or neither set. These leave acc and lock_cnt unchanged.
- acc is a signed accumulator of width clog2(VOTE_TH)+1. An early vote adds 1 and a late vote subtracts 1. The invariant |acc| < VOTE_TH holds.
- Up step: when an early vote would make acc = +VOTE_TH, the same edge performs all of the following.
  - sel <= (sel+1) mod 2**SEL_W, so 7 wraps to 0.
  - acc <= 0.
  - step_up <= 1 for exactly one cycle.
  - lock_cnt <= 0 and locked <= 0.
  - If HOLD_CYC>0, enter HOLD with hold_cnt=HOLD_CYC.
- Down step: the mirror of the up step, triggered at -VOTE_TH. It uses sel-1 with 0 wrapping to 7, and pulses step_dn.
- Latency: sel is registered and updates on the edge that samples the threshold vote. There is no combinational path from inputs to outputs.
- FSM:
  - ACCUM: accepts votes as above.
  - HOLD: all votes are ignored; lock_cnt and acc are held. hold_cnt decrements each cycle. When hold_cnt=1 the next state is ACCUM, so exactly HOLD_CYC cycles are spent in HOLD.
- Lock: each accepted vote that does not cause a step increments lock_cnt, which saturates at LOCK_CNT. locked <= 1 on the edge where lock_cnt reaches LOCK_CNT. locked stays high until a step, a force, or a reset.
- Override (priority over votes and steps):
  - While force_en=1: sel <= force_sel each cycle, acc <= 0, lock_cnt <= 0, locked <= 0, state <= ACCUM, hold_cnt <= 0. No step pulses are issued and votes are ignored.
  - On release of force_en: tracking resumes from the current sel on the following cycle.
- Simultaneous events:
  - force_en together with a threshold vote: force wins and no pulse is issued.
  - rst together with anything: reset wins.

Decomposition:
- Shared package cdr_pkg holds:
  - FSM state encoding (ACCUM=0, HOLD=1).
  - SEL_W default constant.
  - Phase-count constant NPH=8.
- One natural sub-module, vote_accum: a signed up/down counter with ±threshold detect and synchronous clear. It outputs hit_up and hit_dn.
- The FSM, sel register, and lock logic stay in the top level.

Test Plan:
(VOTE_TH=4, HOLD_CYC=3, LOCK_CNT=16)
1. Reset: hold rst=1 for 2 cycles while driving votes -> sel=0, locked=0, step_up=step_dn=0. After release, a single early vote does not step.
2. Up step and hold-off: 4 consecutive valid early votes from sel=0 -> sel=1 on the 4th vote's edge, with step_up high for 1 cycle. The next 3 early votes (HOLD) leave sel=1. 4 further early votes -> sel=2.
3. Wrap-around: force sel=7, release, then 4 early votes -> sel=0 with step_up. Force sel=0, release, then 4 late votes -> sel=7 with step_dn.
4. Lock: 40 alternating early/late votes -> sel unchanged, locked=1 on the 16th accepted vote. Then 4 early votes -> step_up, and locked=0 on the same edge.
5. Vote filtering: 3 early, then 1 cycle with both early and late set, then 1 cycle with pd_valid=0 and early=1, then 1 early vote -> step occurs only on the final vote.
6. Override and reset mid-operation:
   - force_en=1 with force_sel=5 during HOLD -> sel=5 next edge, no pulse. Release, then 4 early votes -> sel=6.
   - Build acc=3, assert rst -> after release, 1 early vote does not step.
